dr_rx_sync: RTL

Dual-rail four-phase link receiver into a single clock domain. Watches a WIDTH-bit dual-rail bundle, detects DATA completion and NULL return, captures decoded bits into a one-entry single-rail output register with valid/ready flow control, and drives the link acknowledge. Sits at the boundary where dual-rail function chains (bit permutations, logic stages) hand results to clocked logic.

---
 rtl/dr_pkg.sv | 11 +
 rtl/dr_completion.sv | 29 ++
 rtl/dr_rx_sync.sv | 108 ++++++++++
 3 files changed

// File: rtl/dr_pkg.sv
// Shared dual-rail definitions: rail indexing and the receiver FSM state codes.
package dr_pkg;

    localparam int RAIL_NUM = 2;
    localparam int RAIL0    = 0;
    localparam int RAIL1    = 1;

    localparam logic [0:0] WAIT_DATA = 1'b0;
    localparam logic [0:0] WAIT_NULL = 1'b1;

endpackage

// File: rtl/dr_completion.sv
// Dual-rail completion detector: flags a fully valid DATA word, an all-NULL
// word, or any illegal 11 pair, and decodes rail1 as the single-rail bit.
module dr_completion
    import dr_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0][RAIL_NUM-1:0] rails,
    output logic                           complete,
    output logic                           is_null,
    output logic                           illegal,
    output logic [WIDTH-1:0]               word
);

    // Fold every pair into word-level complete/null/illegal flags.
    always_comb begin
        complete = 1'b1;
        is_null  = 1'b1;
        illegal  = 1'b0;
        word     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word[i]  = rails[i][RAIL1];
            complete = complete & (rails[i][RAIL0] ^ rails[i][RAIL1]);
            is_null  = is_null & ~(rails[i][RAIL0] | rails[i][RAIL1]);
            illegal  = illegal | (rails[i][RAIL0] & rails[i][RAIL1]);
        end
    end

endmodule

// File: rtl/dr_rx_sync.sv
// Four-phase dual-rail link receiver into the clk domain. Captures each
// completed DATA word into a one-entry valid/ready output register and
// drives the link acknowledge. Define DR_RX_SYNC_SYNC_EN for a two-flop
// synchronizer per rail (asynchronous senders); otherwise a single sample
// flop is used and the sender must be timed to clk.
module dr_rx_sync
    import dr_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0] in,
    output logic                           ack,
    output logic [WIDTH-1:0]               data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           err_o
);

    logic [WIDTH-1:0][RAIL_NUM-1:0] samp;
    logic                           complete;
    logic                           is_null;
    logic                           illegal;
    logic [WIDTH-1:0]               word;
    logic [0:0]                     state;
    logic                           slot_free;
    logic                           load;
    logic                           release_link;

`ifdef DR_RX_SYNC_SYNC_EN
    logic [WIDTH-1:0][RAIL_NUM-1:0] meta;

    // Two-flop synchronizer per rail; only the second stage is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            samp <= '0;
        end else begin
            meta <= in;
            samp <= meta;
        end
    end
`else
    // Single sample flop per rail; sender is launched from clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp <= '0;
        end else begin
            samp <= in;
        end
    end
`endif

    dr_completion #(
        .WIDTH (WIDTH)
    ) u_completion (
        .rails    (samp),
        .complete (complete),
        .is_null  (is_null),
        .illegal  (illegal),
        .word     (word)
    );

    // The slot can take a word if empty or being drained on this same edge.
    always_comb begin
        slot_free    = !valid_o || ready_i;
        load         = (state == WAIT_DATA) && complete && slot_free;
        release_link = (state == WAIT_NULL) && is_null;
    end

    // Handshake FSM: ack rises with a capture and falls once NULL returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_DATA;
            ack   <= 1'b0;
        end else if (load) begin
            state <= WAIT_NULL;
            ack   <= 1'b1;
        end else if (release_link) begin
            state <= WAIT_DATA;
            ack   <= 1'b0;
        end
    end

    // Output register: a reload wins over a simultaneous downstream consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (load) begin
            data_o  <= word;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Sticky protocol error for any sampled 11 pair; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (illegal) begin
            err_o <= 1'b1;
        end
    end

endmodule
